// File: rtl/dsp_stream_arbiter.sv
// Packet-level arbiter sharing one fixed-latency DSP datapath between two stream sinks.
// Optional per-channel packet counters are built when DSP_ARB_PKT_COUNT_EN is defined.
module dsp_stream_arbiter #(
  parameter int LATENCY = 5,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sink0_valid,
  input  logic             sink0_startofpacket,
  input  logic             sink0_endofpacket,
  output logic             sink0_ready,
  input  logic             sink1_valid,
  input  logic             sink1_startofpacket,
  input  logic             sink1_endofpacket,
  output logic             sink1_ready,
  input  logic             source_ready,
  output logic             dsp_sel,
  output logic             dsp_en,
  output logic             source_valid,
  output logic             source_startofpacket,
  output logic             source_endofpacket,
  output logic             source_channel,
  output logic             busy,
  output logic             protocol_err
`ifdef DSP_ARB_PKT_COUNT_EN
  ,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
`endif
);

  if (LATENCY < 1 || CNT_W < 1) begin : g_param_check
    $error("dsp_stream_arbiter: LATENCY and CNT_W must both be >= 1");
  end

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  typedef struct packed {
    logic valid;
    logic sop;
    logic eop;
    logic channel;
  } beat_t;

  state_e state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   sop_seen;
  logic   accept, acc_sop, acc_eop, acc_ch;
  logic   err_set;
  logic   in_flight;
  beat_t  pipe [LATENCY];

  wire elig0 = sink0_valid & sink0_startofpacket;
  wire elig1 = sink1_valid & sink1_startofpacket;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    sink0_ready    = 1'b0;
    sink1_ready    = 1'b0;
    accept         = 1'b0;
    acc_sop        = 1'b0;
    acc_eop        = 1'b0;
    acc_ch         = 1'b0;
    err_set        = 1'b0;
    unique case (state)
      IDLE: begin
        // Beats without sop cannot start a packet; swallow them and flag the framing error.
        sink0_ready = sink0_valid & ~sink0_startofpacket;
        sink1_ready = sink1_valid & ~sink1_startofpacket;
        err_set     = sink0_ready | sink1_ready;
        if (elig0 && elig1) state_nxt = last_grant ? LOCK0 : LOCK1;
        else if (elig0)     state_nxt = LOCK0;
        else if (elig1)     state_nxt = LOCK1;
      end
      LOCK0: begin
        sink0_ready = source_ready;
        accept      = sink0_valid & source_ready;
        acc_sop     = sink0_startofpacket;
        acc_eop     = sink0_endofpacket;
      end
      LOCK1: begin
        sink1_ready = source_ready;
        accept      = sink1_valid & source_ready;
        acc_sop     = sink1_startofpacket;
        acc_eop     = sink1_endofpacket;
        acc_ch      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      if (acc_sop && sop_seen) err_set = 1'b1;
      if (acc_eop) begin
        state_nxt      = IDLE;
        last_grant_nxt = acc_ch;
      end
    end
  end

  // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      sop_seen     <= 1'b0;
      dsp_sel      <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      last_grant   <= last_grant_nxt;
      sop_seen     <= (state_nxt != IDLE) & (sop_seen | accept);
      if (state_nxt == LOCK0) dsp_sel <= 1'b0;
      else if (state_nxt == LOCK1) dsp_sel <= 1'b1;
      if (err_set) protocol_err <= 1'b1;
    end
  end

  // NOTE: the delay line is reset, unlike a data memory, because stale valid bits would emit phantom beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= beat_t'{valid:   accept,
                         sop:     accept & acc_sop,
                         eop:     accept & acc_eop,
                         channel: accept & acc_ch};
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    in_flight = 1'b0;
    for (int i = 0; i < LATENCY; i++) in_flight = in_flight | pipe[i].valid;
  end

  assign dsp_en               = accept;
  assign source_valid         = pipe[LATENCY-1].valid;
  assign source_startofpacket = pipe[LATENCY-1].sop;
  assign source_endofpacket   = pipe[LATENCY-1].eop;
  assign source_channel       = pipe[LATENCY-1].channel;
  assign busy                 = (state != IDLE) | in_flight;

`ifdef DSP_ARB_PKT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (accept && acc_eop) begin
      if (acc_ch) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      else        pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
    end
  end
`endif

endmodule
